i2c_req_arbiter: RTL

//  Shares the single i2c_main bus master between N_REQ on-chip requesters.

---
 rtl/i2c_req_arbiter.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/i2c_req_arbiter.sv
// ---------------------------------------------------------------------------
// i2c_req_arbiter
// Shares one i2c_main bus master between N_REQ on-chip requesters.
// A round-robin arbiter picks a winner, latches its command onto the m_*
// outputs, strobes the master, then waits for completion or a cycle-count
// timeout. The result is returned only to the winner as a one-cycle pulse.
//
// Ports
//   clk, reset        clock (rising edge), async reset (active low)
//   req_valid/addr/rw/wdata   per-requester command, packed by index
//   req_ready         one-hot accept pulse (combinational, IDLE only)
//   rsp_valid         one-hot completion pulse to the winner
//   rsp_rdata/nack/timeout    result, valid with rsp_valid, held until next RESP
//   m_start/addr/rw/wdata     command to the master
//   m_busy/done/nack/rdata    status from the master
//   grant_id          index of current owner
//   busy              arbiter not idle
// ---------------------------------------------------------------------------
module i2c_req_arbiter #(
    parameter int N_REQ   = 4,
    parameter int ADDR_W  = 7,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 4095,
    localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int TMR_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    input  logic [N_REQ-1:0]          req_rw,
    input  logic [N_REQ*DATA_W-1:0]   req_wdata,
    output logic [N_REQ-1:0]          req_ready,
    output logic [N_REQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_nack,
    output logic                      rsp_timeout,
    output logic                      m_start,
    output logic [ADDR_W-1:0]         m_addr,
    output logic                      m_rw,
    output logic [DATA_W-1:0]         m_wdata,
    input  logic                      m_busy,
    input  logic                      m_done,
    input  logic                      m_nack,
    input  logic [DATA_W-1:0]         m_rdata,
    output logic [IDX_W-1:0]          grant_id,
    output logic                      busy
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_DONE, S_RESP} state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    grant_q, grant_d;
    logic [IDX_W-1:0]    last_q, last_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic                m_start_q, m_start_d;
    logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
    logic                m_rw_q, m_rw_d;
    logic [DATA_W-1:0]   m_wdata_q, m_wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                nack_q, nack_d;
    logic                tout_q, tout_d;

    logic [IDX_W-1:0]    win;
    logic                win_found;
    logic [TMR_W-1:0]    timer_inc;
    logic                timeout_hit;

    // Round-robin search starting just after the previous owner.
    always_comb begin
        win       = '0;
        win_found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!win_found && req_valid[(int'(last_q) + k) % N_REQ]) begin
                win       = IDX_W'((int'(last_q) + k) % N_REQ);
                win_found = 1'b1;
            end
        end
    end

    // The comparison uses the post-increment count, so the abort decision is
    // taken in the (TIMEOUT-1)th ISSUE/WAIT_DONE cycle and RESP lands TIMEOUT
    // cycles after the accept.
    assign timer_inc   = timer_q + 1'b1;
    assign timeout_hit = (timer_inc == TMR_W'(TIMEOUT - 1));

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        timer_d   = timer_q;
        m_start_d = m_start_q;
        m_addr_d  = m_addr_q;
        m_rw_d    = m_rw_q;
        m_wdata_d = m_wdata_q;
        rdata_d   = rdata_q;
        nack_d    = nack_q;
        tout_d    = tout_q;
        req_ready = '0;

        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    // Suppress the accept pulse while reset is held so that
                    // every output reads zero during reset.
                    req_ready[win] = reset;
                    m_addr_d  = req_addr[int'(win)*ADDR_W +: ADDR_W];
                    m_rw_d    = req_rw[win];
                    m_wdata_d = req_wdata[int'(win)*DATA_W +: DATA_W];
                    grant_d   = win;
                    timer_d   = '0;
                    m_start_d = 1'b1;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE, S_WAIT_DONE: begin
                timer_d = timer_inc;
                if (m_done) begin
                    // A completion always beats a coincident timeout; an early
                    // m_done while still issuing is taken as completion too.
                    rdata_d   = m_rdata;
                    nack_d    = m_nack;
                    tout_d    = 1'b0;
                    m_start_d = 1'b0;
                    state_d   = S_RESP;
                end else if (timeout_hit) begin
                    rdata_d   = '0;
                    nack_d    = 1'b0;
                    tout_d    = 1'b1;
                    m_start_d = 1'b0;
                    state_d   = S_RESP;
                end else if (state_q == S_ISSUE && m_busy) begin
                    m_start_d = 1'b0;
                    state_d   = S_WAIT_DONE;
                end
            end
            S_RESP: begin
                last_d  = grant_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            grant_q   <= '0;
            last_q    <= IDX_W'(N_REQ - 1);
            timer_q   <= '0;
            m_start_q <= 1'b0;
            m_addr_q  <= '0;
            m_rw_q    <= 1'b0;
            m_wdata_q <= '0;
            rdata_q   <= '0;
            nack_q    <= 1'b0;
            tout_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            timer_q   <= timer_d;
            m_start_q <= m_start_d;
            m_addr_q  <= m_addr_d;
            m_rw_q    <= m_rw_d;
            m_wdata_q <= m_wdata_d;
            rdata_q   <= rdata_d;
            nack_q    <= nack_d;
            tout_q    <= tout_d;
        end
    end

    assign rsp_valid   = (state_q == S_RESP) ? (N_REQ'(1) << grant_q) : '0;
    assign rsp_rdata   = rdata_q;
    assign rsp_nack    = nack_q;
    assign rsp_timeout = tout_q;
    assign m_start     = m_start_q;
    assign m_addr      = m_addr_q;
    assign m_rw        = m_rw_q;
    assign m_wdata     = m_wdata_q;
    assign grant_id    = grant_q;
    assign busy        = (state_q != S_IDLE);

endmodule
